crossing_scheduler: RTL



---
 rtl/crossing_scheduler_pkg.sv | 22 ++
 rtl/crossing_scheduler_phase_timer.sv | 27 ++
 rtl/crossing_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/crossing_scheduler_pkg.sv
// Shared state codes and default phase durations
// for the pedestrian crossing scheduler.
package crossing_scheduler_pkg;

  typedef enum logic [2:0] {
    CAR_GO    = 3'd0,
    CAR_WAIT  = 3'd1,
    CAR_AMBER = 3'd2,
    ALL_RED1  = 3'd3,
    PED_WALK  = 3'd4,
    PED_CLEAR = 3'd5,
    ALL_RED2  = 3'd6
  } state_t;

  localparam int DEF_MIN_GREEN = 8;
  localparam int DEF_AMBER     = 3;
  localparam int DEF_ALL_RED   = 1;
  localparam int DEF_WALK      = 6;
  localparam int DEF_CLEAR     = 4;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/crossing_scheduler_phase_timer.sv
// Phase timer: clears on state change, holds on request,
// saturates at all-ones, flags the last cycle of a phase.
module crossing_scheduler_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] limit,
  output logic             done,
  output logic             lsb
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear)
      cnt <= '0;
    else if (!hold && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  assign done = (cnt == limit - 1'b1);
  assign lsb  = cnt[0];

endmodule

// File: rtl/crossing_scheduler.sv
// Pedestrian crossing scheduler: request latch, phase FSM
// and Moore lamp decode for one road and its crosswalk.
module crossing_scheduler
  import crossing_scheduler_pkg::*;
#(
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int AMBER     = DEF_AMBER,
  parameter int ALL_RED   = DEF_ALL_RED,
  parameter int WALK      = DEF_WALK,
  parameter int CLEAR     = DEF_CLEAR,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_a,
  input  logic       key_b,
  output logic       car_red,
  output logic       car_amber,
  output logic       car_green,
  output logic       ped_red,
  output logic       ped_green,
  output logic       req_pending,
  output logic [2:0] phase
);

  state_t           state, nxt;
  logic             req, key, done, lsb;
  logic             clr, hold;
  logic [CNT_W-1:0] limit;

  assign key  = key_a | key_b;
  assign clr  = (nxt != state);
  assign hold = (state == CAR_WAIT);

  always_comb begin
    case (state)
      CAR_AMBER:          limit = CNT_W'(AMBER);
      ALL_RED1, ALL_RED2: limit = CNT_W'(ALL_RED);
      PED_WALK:           limit = CNT_W'(WALK);
      PED_CLEAR:          limit = CNT_W'(CLEAR);
      default:            limit = CNT_W'(MIN_GREEN);
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      CAR_GO:
        if (done) nxt = (req | key) ? CAR_AMBER : CAR_WAIT;
      CAR_WAIT:
        if (req | key) nxt = CAR_AMBER;
      CAR_AMBER: if (done) nxt = ALL_RED1;
      ALL_RED1:  if (done) nxt = PED_WALK;
      PED_WALK:  if (done) nxt = PED_CLEAR;
      PED_CLEAR: if (done) nxt = ALL_RED2;
      ALL_RED2:  if (done) nxt = CAR_GO;
      default:   nxt = CAR_GO;
    endcase
  end

  // Entering WALK serves the request, so it wins over a new press.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CAR_GO;
      req   <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == PED_WALK && state != PED_WALK)
        req <= 1'b0;
      else if (key && state != PED_WALK)
        req <= 1'b1;
    end
  end

  crossing_scheduler_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(clr),
    .hold (hold),
    .limit(limit),
    .done (done),
    .lsb  (lsb)
  );

  always_comb begin
    car_red   = 1'b0;
    car_amber = 1'b0;
    car_green = 1'b0;
    ped_red   = 1'b1;
    ped_green = 1'b0;
    case (state)
      CAR_AMBER: car_amber = 1'b1;
      ALL_RED1, ALL_RED2: car_red = 1'b1;
      PED_WALK: begin
        car_red   = 1'b1;
        ped_red   = 1'b0;
        ped_green = 1'b1;
      end
      PED_CLEAR: begin
        car_red   = 1'b1;
        ped_red   = 1'b0;
        ped_green = ~lsb;
      end
      default: car_green = 1'b1;
    endcase
  end

  assign req_pending = req;
  assign phase       = state;

endmodule
